// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Word handed back to the requester when the memory never answers.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Timeout counter width; TIMEOUT is limited to 1..255.
  localparam int TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one variable-latency
// memory: one transaction at a time, data first with bounded fetch starvation,
// hung accesses aborted after TIMEOUT busy cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                STARVE_LIMIT = 4,
  parameter int                TIMEOUT      = 255,
  parameter logic [DATA_W-1:0] ERR_DATA     = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall,
  output logic              bus_err
);

  localparam int                      STARVE_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]     STARVE_MAX   = STARVE_W'(STARVE_LIMIT);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT - 1);

  arb_state_t               r_state;
  arb_state_t               w_stateNext;
  owner_t                   r_owner;
  logic [STARVE_W-1:0]      r_starveCnt;
  logic [TIMEOUT_CNT_W-1:0] r_timeoutCnt;

  logic              r_mReq;
  logic              r_mWe;
  logic [ADDR_W-1:0] r_mAddr;
  logic [DATA_W-1:0] r_mWdata;
  logic [DATA_W-1:0] r_iRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic              r_iReady;
  logic              r_dReady;
  logic              r_busErr;

  logic w_start;
  logic w_grantI;
  logic w_done;
  logic w_timedOut;

  // Next-state logic: pick an owner in IDLE, finish on ack or on the last
  // permitted busy cycle (an ack in that same cycle still counts as success).
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_grantI    = 1'b0;
    w_done      = 1'b0;
    w_timedOut  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          w_start     = 1'b1;
          w_grantI    = i_req && (!d_req || (r_starveCnt == STARVE_MAX));
          w_stateNext = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (m_ack) begin
          w_done      = 1'b1;
          w_stateNext = ST_RESP;
        end else if (r_timeoutCnt == TIMEOUT_LAST) begin
          w_done      = 1'b1;
          w_timedOut  = 1'b1;
          w_stateNext = ST_RESP;
        end
      end
      ST_RESP: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Memory-side request registers, starvation and timeout counters, and the
  // per-port response registers; ready pulses last exactly the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_I;
      r_mReq       <= 1'b0;
      r_mWe        <= 1'b0;
      r_mAddr      <= '0;
      r_mWdata     <= '0;
      r_iRdata     <= '0;
      r_dRdata     <= '0;
      r_iReady     <= 1'b0;
      r_dReady     <= 1'b0;
      r_busErr     <= 1'b0;
      r_starveCnt  <= '0;
      r_timeoutCnt <= '0;
    end else begin
      r_iReady <= 1'b0;
      r_dReady <= 1'b0;
      if (w_start) begin
        r_mReq       <= 1'b1;
        r_timeoutCnt <= '0;
        if (w_grantI) begin
          r_owner  <= OWN_I;
          r_mWe    <= 1'b0;
          r_mAddr  <= i_addr;
          r_mWdata <= '0;
        end else begin
          r_owner  <= OWN_D;
          r_mWe    <= d_we;
          r_mAddr  <= d_addr;
          r_mWdata <= d_wdata;
        end
        if (w_grantI || !i_req) begin
          r_starveCnt <= '0;
        end else if (r_starveCnt != STARVE_MAX) begin
          r_starveCnt <= r_starveCnt + 1'b1;
        end
      end else if (w_done) begin
        r_mReq <= 1'b0;
        if (w_timedOut) begin
          r_busErr <= 1'b1;
        end
        if (r_owner == OWN_I) begin
          r_iReady <= 1'b1;
          r_iRdata <= w_timedOut ? ERR_DATA : m_rdata;
        end else begin
          r_dReady <= 1'b1;
          if (!r_mWe) begin
            r_dRdata <= w_timedOut ? ERR_DATA : m_rdata;
          end
        end
      end else if (r_state == ST_BUSY) begin
        r_timeoutCnt <= r_timeoutCnt + 1'b1;
      end
    end
  end

  assign m_req   = r_mReq;
  assign m_we    = r_mWe;
  assign m_addr  = r_mAddr;
  assign m_wdata = r_mWdata;
  assign i_rdata = r_iRdata;
  assign d_rdata = r_dRdata;
  assign i_ready = r_iReady;
  assign d_ready = r_dReady;
  assign bus_err = r_busErr;

  // A port stalls the pipeline while it asks and has not yet been answered.
  assign stall = (i_req & ~r_iReady) | (d_req & ~r_dReady);

endmodule
